// File: rtl/element_wise_out_data_cvt_cell.sv
// Converts an FP32 element-wise result to FP16 or a 2^accrc-scaled saturated integer.
// Three-stage pipeline (unpack, align/round, saturate/pack) with valid, clock enable and along-path.
module element_wise_out_data_cvt_cell #(
    parameter bit EN_ROUND                = 1'b1,
    parameter bit FP16_OUT_DATA_SUPPORTED = 1'b1,
    parameter bit INT_OUT_DATA_SUPPORTED  = 1'b1,
    parameter int INFO_ALONG_WIDTH        = 2,
    parameter int SIM_DELAY               = 1
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        aclken,
    input  logic                        bypass,
    input  logic [1:0]                  out_data_fmt,
    input  logic [2:0]                  integer_type,
    input  logic [5:0]                  fixed_point_quat_accrc,
    input  logic [31:0]                 cvt_cell_i_op_x,
    input  logic [INFO_ALONG_WIDTH-1:0] cvt_cell_i_info_along,
    input  logic                        cvt_cell_i_vld,
    output logic [31:0]                 cvt_cell_o_res,
    output logic [INFO_ALONG_WIDTH-1:0] cvt_cell_o_info_along,
    output logic                        cvt_cell_o_vld
);

    typedef enum logic [1:0] {
        FMT_FP16 = 2'b00, FMT_INT = 2'b01, FMT_NONE = 2'b10, FMT_RSVD = 2'b11
    } fmt_e;

    typedef enum logic [2:0] {
        IT_U8 = 3'b000, IT_S8, IT_U16, IT_S16, IT_U32, IT_S32, IT_R6, IT_R7
    } int_type_e;

    // Register update delay is not modelled in synthesizable logic.
    if (SIM_DELAY < 0) begin : g_sim_delay_unused
    end

    // Stage 1: unpacked operand plus the configuration that travels with it
    logic                        s1_vld, s1_byp, s1_sign, s1_inf, s1_nan;
    fmt_e                        s1_fmt;
    int_type_e                   s1_ityp;
    logic [5:0]                  s1_accrc;
    logic [31:0]                 s1_raw;
    logic [INFO_ALONG_WIDTH-1:0] s1_info;
    logic [7:0]                  s1_exp;
    logic [23:0]                 s1_man;

    // Stage 2: aligned/rounded magnitudes for both output paths
    logic                        s2_vld, s2_byp, s2_sign, s2_inf, s2_nan, s2_huf, s2_sat;
    fmt_e                        s2_fmt;
    int_type_e                   s2_ityp;
    logic [31:0]                 s2_raw;
    logic [INFO_ALONG_WIDTH-1:0] s2_info;
    logic signed [9:0]           s2_hexp;
    logic [9:0]                  s2_hman;
    logic [39:0]                 s2_mag;

    logic [7:0]        in_exp;
    logic [22:0]       in_frac;
    logic signed [9:0] sh, e16;
    logic [9:0]        rsh;
    logic [24:0]       rtmp;
    logic [39:0]       int_mag;
    logic              int_sat;
    logic [10:0]       hround;

    logic        type_ok;
    logic [31:0] lim_p, lim_n, lim, mag_c, int_res, res;
    logic [15:0] half;

    assign in_exp  = cvt_cell_i_op_x[30:23];
    assign in_frac = cvt_cell_i_op_x[22:0];

    // Integer scale exponent: value = man * 2^(exp - 150 + accrc)
    always_comb begin
        sh      = $signed({2'b00, s1_exp}) + $signed({4'b0000, s1_accrc}) - 10'sd150;
        rsh     = -sh;
        rtmp    = {s1_man, 1'b0} >> rsh[4:0];
        int_mag = '0;
        if (sh >= 0)
            int_mag = {16'h0000, s1_man} << sh[4:0];
        else if (rsh < 10'd25)
            int_mag = {16'h0000, rtmp[24:1]} + {39'b0, EN_ROUND & rtmp[0]};
        int_sat = s1_inf || (sh > 10'sd16);
        e16     = $signed({2'b00, s1_exp}) - 10'sd112;
        hround  = {1'b0, s1_man[22:13]} + {10'b0, EN_ROUND & s1_man[12]};
    end

    always_comb begin
        type_ok = 1'b1;
        lim_p   = '0;
        lim_n   = '0;
        case (s2_ityp)
            IT_U8:   lim_p = 32'd255;
            IT_S8:   begin lim_p = 32'd127;        lim_n = 32'd128;        end
            IT_U16:  lim_p = 32'd65535;
            IT_S16:  begin lim_p = 32'd32767;      lim_n = 32'd32768;      end
            IT_U32:  lim_p = 32'hFFFF_FFFF;
            IT_S32:  begin lim_p = 32'h7FFF_FFFF;  lim_n = 32'h8000_0000;  end
            default: type_ok = 1'b0;
        endcase
        // Unsigned types have lim_n = 0, so any negative input clamps to zero
        lim     = s2_sign ? lim_n : lim_p;
        mag_c   = (s2_sat || (s2_mag > {8'h00, lim})) ? lim : s2_mag[31:0];
        int_res = '0;
        if (type_ok && !s2_nan)
            int_res = s2_sign ? ('0 - mag_c) : mag_c;

        if (s2_nan)
            half = 16'h7E00;
        else if (s2_inf || (s2_hexp > 10'sd30))
            half = {s2_sign, 15'h7C00};
        else if (s2_huf)
            half = {s2_sign, 15'h0000};
        else
            half = {s2_sign, s2_hexp[4:0], s2_hman};

        res = '0;
        if (s2_byp)
            res = s2_raw;
        else if (s2_fmt == FMT_FP16 && FP16_OUT_DATA_SUPPORTED)
            res = {16'h0000, half};
        else if (s2_fmt == FMT_INT && INT_OUT_DATA_SUPPORTED)
            res = int_res;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s1_vld <= 1'b0; s1_byp <= 1'b0; s1_sign <= 1'b0; s1_inf <= 1'b0; s1_nan <= 1'b0;
            s1_fmt <= FMT_FP16; s1_ityp <= IT_U8; s1_accrc <= '0; s1_raw <= '0;
            s1_info <= '0; s1_exp <= '0; s1_man <= '0;
            s2_vld <= 1'b0; s2_byp <= 1'b0; s2_sign <= 1'b0; s2_inf <= 1'b0; s2_nan <= 1'b0;
            s2_huf <= 1'b0; s2_sat <= 1'b0; s2_fmt <= FMT_FP16; s2_ityp <= IT_U8;
            s2_raw <= '0; s2_info <= '0; s2_hexp <= '0; s2_hman <= '0; s2_mag <= '0;
            cvt_cell_o_vld <= 1'b0; cvt_cell_o_res <= '0; cvt_cell_o_info_along <= '0;
        end else if (aclken) begin
            s1_vld <= cvt_cell_i_vld;
            if (cvt_cell_i_vld) begin
                s1_byp   <= bypass;
                s1_fmt   <= fmt_e'(out_data_fmt);
                s1_ityp  <= int_type_e'(integer_type);
                s1_accrc <= fixed_point_quat_accrc;
                s1_raw   <= cvt_cell_i_op_x;
                s1_info  <= cvt_cell_i_info_along;
                s1_sign  <= cvt_cell_i_op_x[31];
                s1_exp   <= in_exp;
                s1_man   <= (in_exp == '0) ? '0 : {1'b1, in_frac};
                s1_inf   <= (in_exp == '1) && (in_frac == '0);
                s1_nan   <= (in_exp == '1) && (in_frac != '0);
            end

            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_byp  <= s1_byp;
                s2_fmt  <= s1_fmt;
                s2_ityp <= s1_ityp;
                s2_raw  <= s1_raw;
                s2_info <= s1_info;
                s2_sign <= s1_sign;
                s2_inf  <= s1_inf;
                s2_nan  <= s1_nan;
                s2_hexp <= e16 + $signed({9'b0, hround[10]});
                s2_hman <= hround[9:0];
                s2_huf  <= e16 < 10'sd1;
                s2_mag  <= int_mag;
                s2_sat  <= int_sat;
            end

            cvt_cell_o_vld <= s2_vld;
            if (s2_vld) begin
                cvt_cell_o_res        <= res;
                cvt_cell_o_info_along <= s2_info;
            end
        end
    end

endmodule

// File: tb/tb_element_wise_out_data_cvt_cell.sv
// Self-checking bench: directed spec vectors plus randomized batches against a real-arithmetic model.
`timescale 1ns/1ps
module tb_element_wise_out_data_cvt_cell;

    localparam bit EN_ROUND = 1'b1;
    localparam int IAW      = 2;

    logic           aclk = 1'b0;
    logic           areset, aclken, bypass;
    logic [1:0]     out_data_fmt;
    logic [2:0]     integer_type;
    logic [5:0]     fixed_point_quat_accrc;
    logic [31:0]    cvt_cell_i_op_x;
    logic [IAW-1:0] cvt_cell_i_info_along;
    logic           cvt_cell_i_vld;
    logic [31:0]    cvt_cell_o_res;
    logic [IAW-1:0] cvt_cell_o_info_along;
    logic           cvt_cell_o_vld;

    element_wise_out_data_cvt_cell #(
        .EN_ROUND(EN_ROUND),
        .FP16_OUT_DATA_SUPPORTED(1'b1),
        .INT_OUT_DATA_SUPPORTED(1'b1),
        .INFO_ALONG_WIDTH(IAW),
        .SIM_DELAY(1)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .aclken(aclken),
        .bypass(bypass),
        .out_data_fmt(out_data_fmt),
        .integer_type(integer_type),
        .fixed_point_quat_accrc(fixed_point_quat_accrc),
        .cvt_cell_i_op_x(cvt_cell_i_op_x),
        .cvt_cell_i_info_along(cvt_cell_i_info_along),
        .cvt_cell_i_vld(cvt_cell_i_vld),
        .cvt_cell_o_res(cvt_cell_o_res),
        .cvt_cell_o_info_along(cvt_cell_o_info_along),
        .cvt_cell_o_vld(cvt_cell_o_vld)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0]    res;
        logic [IAW-1:0] info;
        int             cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          ecyc   = 0;
    string       tag    = "init";
    logic        prev_vld;
    logic [31:0] prev_res;

    function automatic real pow2(input int k);
        real r;
        r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp32_mag(input logic [31:0] x);
        if (x[30:23] == 8'd0) return 0.0;
        return (1.0 + real'(x[22:0]) / 8388608.0) * pow2(int'(x[30:23]) - 127);
    endfunction

    function automatic logic [15:0] model_fp16(input logic [31:0] x);
        logic s;
        real  a, q, qr;
        int   e;
        logic [4:0] eb;
        logic [9:0] mb;
        s = x[31];
        if (x[30:23] == 8'hFF) return (x[22:0] != 0) ? 16'h7E00 : {s, 15'h7C00};
        a = fp32_mag(x);
        if (a < pow2(-14)) return {s, 15'h0000};
        e = -14;
        while (a >= pow2(e + 1)) e++;
        q  = a / pow2(e) * 1024.0;
        qr = EN_ROUND ? $floor(q + 0.5) : $floor(q);
        if (qr >= 2048.0) begin
            e++;
            qr = 1024.0;
        end
        if (e > 15) return {s, 15'h7C00};
        eb = 5'(e + 15);
        mb = 10'(longint'(qr) - 1024);
        return {s, eb, mb};
    endfunction

    function automatic logic [31:0] model_int(input logic [31:0] x, input logic [2:0] it, input int acc);
        longint lo, hi;
        real    v, r;
        case (it)
            3'd0: begin lo = 0;                 hi = 255;          end
            3'd1: begin lo = -128;              hi = 127;          end
            3'd2: begin lo = 0;                 hi = 65535;        end
            3'd3: begin lo = -32768;            hi = 32767;        end
            3'd4: begin lo = 0;                 hi = 64'd4294967295; end
            3'd5: begin lo = -64'sd2147483648;  hi = 64'sd2147483647; end
            default: return 32'h0;
        endcase
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] != 0) return 32'h0;
            return 32'(x[31] ? lo : hi);
        end
        v = fp32_mag(x) * pow2(acc);
        r = EN_ROUND ? $floor(v + 0.5) : $floor(v);
        if (x[31]) r = -r;
        if (r > real'(hi)) r = real'(hi);
        if (r < real'(lo)) r = real'(lo);
        return 32'(longint'(r));
    endfunction

    function automatic logic [31:0] model(input logic [31:0] x, input logic byp, input logic [1:0] fmt,
                                          input logic [2:0] it, input int acc);
        if (byp) return x;
        case (fmt)
            2'b00:   return {16'h0000, model_fp16(x)};
            2'b01:   return model_int(x, it, acc);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_x();
        logic [7:0]  e;
        logic [22:0] m;
        int unsigned k;
        k = $urandom_range(0, 11);
        m = 23'($urandom);
        if (k == 0) e = 8'd0;
        else if (k == 1) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 1) m = '0;
        end else begin
            e = 8'($urandom_range(100, 160));
            if (k == 2) m[12:0] = 13'h1000;
        end
        return {1'($urandom), e, m};
    endfunction

    // One clock: output checks only on enabled edges; disabled edges must hold outputs
    task automatic tick();
        logic en;
        logic exp_v;
        exp_t e;
        en = aclken;
        @(posedge aclk);
        #1;
        if (areset) return;
        if (en) begin
            ecyc++;
            exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == ecyc);
            checks++;
            assert (cvt_cell_o_vld === exp_v) else begin
                errors++;
                $error("FAIL %s o_vld: got=%b exp=%b at cycle %0d", tag, cvt_cell_o_vld, exp_v, ecyc);
            end
            if (exp_v) begin
                e = exp_q.pop_front();
                if (cvt_cell_o_vld) begin
                    checks++;
                    assert (cvt_cell_o_res === e.res) else begin
                        errors++;
                        $error("FAIL %s o_res: got=%h exp=%h", tag, cvt_cell_o_res, e.res);
                    end
                    checks++;
                    assert (cvt_cell_o_info_along === e.info) else begin
                        errors++;
                        $error("FAIL %s o_info_along: got=%b exp=%b", tag, cvt_cell_o_info_along, e.info);
                    end
                end
            end
        end else begin
            checks++;
            assert ({cvt_cell_o_vld, cvt_cell_o_res} === {prev_vld, prev_res}) else begin
                errors++;
                $error("FAIL %s hold: got=%b/%h exp=%b/%h", tag, cvt_cell_o_vld, cvt_cell_o_res,
                       prev_vld, prev_res);
            end
        end
        prev_vld = cvt_cell_o_vld;
        prev_res = cvt_cell_o_res;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] expv);
        exp_t e;
        cvt_cell_i_op_x = x;
        cvt_cell_i_vld  = 1'b1;
        e.res  = expv;
        e.info = cvt_cell_i_info_along;
        e.cyc  = ecyc + 3;
        exp_q.push_back(e);
        tick();
        cvt_cell_i_vld = 1'b0;
    endtask

    task automatic send_rnd(input logic [31:0] x);
        send(x, model(x, bypass, out_data_fmt, integer_type, int'(fixed_point_quat_accrc)));
    endtask

    task automatic drain();
        repeat (6) tick();
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL %s drain: got=%0d pending exp=0", tag, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic cfg(input logic byp, input logic [1:0] fmt, input logic [2:0] it, input logic [5:0] acc);
        bypass = byp;
        out_data_fmt = fmt;
        integer_type = it;
        fixed_point_quat_accrc = acc;
    endtask

    initial begin
        areset = 1'b1; aclken = 1'b1; cvt_cell_i_vld = 1'b0;
        cvt_cell_i_op_x = '0; cvt_cell_i_info_along = '0;
        cfg(1'b0, 2'b00, 3'd0, 6'd0);
        repeat (3) @(posedge aclk);
        #1;
        tag = "reset";
        checks++;
        assert (cvt_cell_o_vld === 1'b0) else begin errors++; $error("FAIL reset o_vld: got=%b exp=0", cvt_cell_o_vld); end
        checks++;
        assert (cvt_cell_o_res === 32'h0) else begin errors++; $error("FAIL reset o_res: got=%h exp=0", cvt_cell_o_res); end
        checks++;
        assert (cvt_cell_o_info_along === 2'b00) else begin errors++; $error("FAIL reset o_info: got=%b exp=00", cvt_cell_o_info_along); end
        areset = 1'b0;
        prev_vld = 1'b0; prev_res = '0;

        tag = "fp16";
        cvt_cell_i_info_along = 2'b10;
        send(32'h3FCCCCCD, 32'h00003E66);
        send(32'hBFCCCCCD, 32'h0000BE66);
        send(32'h00000000, 32'h00000000);
        send(32'h4788B800, 32'h00007C00);
        send(32'hB58637BD, 32'h00008000);
        send(32'h7FC00000, 32'h00007E00);
        drain();

        tag = "s16_acc8";
        cfg(1'b0, 2'b01, 3'd3, 6'd8);
        send(32'h3FCCCCCD, 32'h0000019A);
        send(32'hBFCCCCCD, 32'hFFFFFE66);
        send(32'h40000000, 32'h00000200);
        send(32'h43480000, 32'h00007FFF);
        send(32'hC3480000, 32'hFFFF8000);
        drain();

        tag = "s16_tie";
        cfg(1'b0, 2'b01, 3'd3, 6'd0);
        send(32'h40200000, 32'h00000003);
        send(32'hC0200000, 32'hFFFFFFFD);
        drain();

        tag = "u8_sat";
        cfg(1'b0, 2'b01, 3'd0, 6'd0);
        send(32'hC0400000, 32'h00000000);
        send(32'h43960000, 32'h000000FF);
        drain();

        tag = "bypass";
        cfg(1'b1, 2'b00, 3'd0, 6'd0);
        send(32'h12345678, 32'h12345678);
        drain();

        tag = "fmt_none";
        cfg(1'b0, 2'b10, 3'd0, 6'd0);
        send(32'h3FCCCCCD, 32'h00000000);
        drain();

        tag = "burst";
        cfg(1'b0, 2'b00, 3'd0, 6'd0);
        cvt_cell_i_info_along = 2'b01;
        for (int i = 0; i < 4; i++) send_rnd(rnd_x());
        aclken = 1'b0;
        cvt_cell_i_vld = 1'b1;
        cvt_cell_i_op_x = 32'h3F800000;
        tick();
        tick();
        cvt_cell_i_vld = 1'b0;
        aclken = 1'b1;
        for (int i = 0; i < 4; i++) send_rnd(rnd_x());
        drain();

        tag = "rst_mid";
        for (int i = 0; i < 3; i++) send_rnd(rnd_x());
        #2 areset = 1'b1;
        #1;
        checks++;
        assert (cvt_cell_o_vld === 1'b0) else begin errors++; $error("FAIL rst_mid o_vld: got=%b exp=0", cvt_cell_o_vld); end
        checks++;
        assert (cvt_cell_o_res === 32'h0) else begin errors++; $error("FAIL rst_mid o_res: got=%h exp=0", cvt_cell_o_res); end
        exp_q.delete();
        tick();
        tick();
        areset = 1'b0;
        prev_vld = 1'b0; prev_res = '0;
        for (int i = 0; i < 3; i++) send_rnd(rnd_x());
        drain();

        tag = "rand";
        for (int b = 0; b < 30; b++) begin
            int unsigned f;
            f = $urandom_range(0, 9);
            cfg(($urandom_range(0, 9) == 0),
                (f < 4) ? 2'b00 : (f < 9) ? 2'b01 : 2'(2 + $urandom_range(0, 1)),
                3'($urandom_range(0, 5)),
                6'($urandom_range(0, 31)));
            for (int i = 0; i < int'($urandom_range(4, 10)); i++) begin
                cvt_cell_i_info_along = 2'($urandom);
                send_rnd(rnd_x());
            end
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
